// File: rtl/game_scoreboard.sv
// Scoreboard and game timer: per-player BCD scores, session high score,
// BCD seconds timer (count-up or countdown) and the IDLE/RUN/OVER phase.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start           begin a game from IDLE or OVER
//   count_down      timer mode latched at start (1 = countdown)
//   time_limit      BCD countdown start value latched at start
//   point           one-cycle point pulse per player
//   game_over       engine-reported end of game
//   state           0 = IDLE, 1 = RUN, 2 = OVER
//   score_bcd       player i at [i*4*SCORE_DIGITS +: 4*SCORE_DIGITS]
//   high_bcd        session high score
//   time_bcd        timer value in seconds
//   sec_tick        high during the cycle on whose closing edge the timer steps
//   time_up         high during the RUN cycle in which the countdown reads 0
//   new_high        high in OVER when this game raised high_bcd
module game_scoreboard #(
    parameter int CLK_HZ       = 50000000,
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_DIGITS = 2,
    parameter int TIME_DIGITS  = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                count_down,
    input  logic [4*TIME_DIGITS-1:0]            time_limit,
    input  logic [NUM_PLAYERS-1:0]              point,
    input  logic                                game_over,
    output logic [1:0]                          state,
    output logic [NUM_PLAYERS*4*SCORE_DIGITS-1:0] score_bcd,
    output logic [4*SCORE_DIGITS-1:0]           high_bcd,
    output logic [4*TIME_DIGITS-1:0]            time_bcd,
    output logic                                sec_tick,
    output logic                                time_up,
    output logic                                new_high
);

    localparam int SW = 4 * SCORE_DIGITS;
    localparam int TW = 4 * TIME_DIGITS;
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Saturating BCD increment: an all-9s value has a carry out and stays put.
    function automatic logic [SW-1:0] score_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return c ? v : r;
    endfunction

    function automatic logic [TW-1:0] time_inc(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < TIME_DIGITS; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return c ? v : r;
    endfunction

    // Never called on zero: expiry is detected before the timer would step.
    function automatic logic [TW-1:0] time_dec(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < TIME_DIGITS; i++) begin
            if (b) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return b ? v : r;
    endfunction

    state_t                          state_q, state_d;
    logic [NUM_PLAYERS-1:0][SW-1:0]  score_q, score_d;
    logic [SW-1:0]                   high_q, high_d;
    logic [TW-1:0]                   time_q, time_d;
    logic [PW-1:0]                   presc_q, presc_d;
    logic                            mode_q, mode_d;
    logic                            new_high_q, new_high_d;
    logic                            sec_tick_q, sec_tick_d;
    logic                            time_up_q, time_up_d;
    logic [SW-1:0]                   max_s;

    always_comb begin
        max_s = score_q[0];
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (score_q[i] > max_s) begin
                max_s = score_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        time_d     = time_q;
        presc_d    = presc_q;
        mode_d     = mode_q;
        new_high_d = new_high_q;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                // Packed BCD compares correctly as unsigned binary.
                if (state_q == ST_OVER && max_s > high_q) begin
                    high_d     = max_s;
                    new_high_d = 1'b1;
                end
                if (start) begin
                    state_d    = ST_RUN;
                    score_d    = '0;
                    presc_d    = '0;
                    mode_d     = count_down;
                    time_d     = count_down ? time_limit : '0;
                    new_high_d = 1'b0;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (point[i]) begin
                        score_d[i] = score_inc(score_q[i]);
                    end
                end
                if (mode_q && time_q == '0) begin
                    state_d = ST_OVER;
                end else if (presc_q == PMAX) begin
                    presc_d = '0;
                    time_d  = mode_q ? time_dec(time_q) : time_inc(time_q);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (game_over) begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pulses are registered so they coincide with the cycle they describe.
        sec_tick_d = (state_d == ST_RUN) && (presc_d == PMAX);
        time_up_d  = (state_d == ST_RUN) && mode_d && (time_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            high_q     <= '0;
            time_q     <= '0;
            presc_q    <= '0;
            mode_q     <= 1'b0;
            new_high_q <= 1'b0;
            sec_tick_q <= 1'b0;
            time_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            mode_q     <= mode_d;
            new_high_q <= new_high_d;
            sec_tick_q <= sec_tick_d;
            time_up_q  <= time_up_d;
        end
    end

    assign state     = state_q;
    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign time_bcd  = time_q;
    assign sec_tick  = sec_tick_q;
    assign time_up   = time_up_q;
    assign new_high  = new_high_q;

endmodule

// File: tb/tb_game_scoreboard.sv
// Directed bench for game_scoreboard: a 2-player/4-digit-timer instance
// and a 1-player/1-digit-timer instance share clock and controls.
module tb_game_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        count_down;
    logic [15:0] time_limit;
    logic [3:0]  time_limit1;
    logic [1:0]  point;
    logic        game_over;

    logic [1:0]  state;
    logic [15:0] score_bcd;
    logic [7:0]  high_bcd;
    logic [15:0] time_bcd;
    logic        sec_tick;
    logic        time_up;
    logic        new_high;

    logic [1:0]  state1;
    logic [7:0]  score1;
    logic [7:0]  high1;
    logic [3:0]  time1;
    logic        sec_tick1;
    logic        time_up1;
    logic        new_high1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    game_scoreboard #(
        .CLK_HZ(4), .NUM_PLAYERS(2), .SCORE_DIGITS(2), .TIME_DIGITS(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .count_down(count_down),
        .time_limit(time_limit), .point(point), .game_over(game_over),
        .state(state), .score_bcd(score_bcd), .high_bcd(high_bcd),
        .time_bcd(time_bcd), .sec_tick(sec_tick), .time_up(time_up),
        .new_high(new_high)
    );

    game_scoreboard #(
        .CLK_HZ(4), .NUM_PLAYERS(1), .SCORE_DIGITS(2), .TIME_DIGITS(1)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start), .count_down(count_down),
        .time_limit(time_limit1), .point(point[0]), .game_over(game_over),
        .state(state1), .score_bcd(score1), .high_bcd(high1),
        .time_bcd(time1), .sec_tick(sec_tick1), .time_up(time_up1),
        .new_high(new_high1)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; point = 2'b11;
        step(2);
        tests++;
        if (state !== 2'd0) begin
            fails++; $display("FAIL reset_state got %0d want 0", state);
        end
        tests++;
        if (score_bcd !== 16'h0) begin
            fails++; $display("FAIL reset_score got %h want 0000", score_bcd);
        end
        tests++;
        if (high_bcd !== 8'h0) begin
            fails++; $display("FAIL reset_high got %h want 00", high_bcd);
        end
        tests++;
        if (time_bcd !== 16'h0) begin
            fails++; $display("FAIL reset_time got %h want 0000", time_bcd);
        end
        tests++;
        if ({sec_tick, time_up, new_high} !== 3'b000) begin
            fails++;
            $display("FAIL reset_pulses got %b want 000",
                     {sec_tick, time_up, new_high});
        end
        tests++;
        if (state1 !== 2'd0 || time1 !== 4'h0) begin
            fails++; $display("FAIL reset_dut1 got %0d/%h want 0/0", state1, time1);
        end
        reset = 1'b0; start = 1'b0; point = 2'b00;
        step(1);
    endtask

    task automatic test_count_up;
        int ticks;
        int ticks1;
        ticks = 0; ticks1 = 0;
        count_down = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        tests++;
        if (state !== 2'd1 || time_bcd !== 16'h0) begin
            fails++; $display("FAIL up_start got %0d/%h want 1/0000", state, time_bcd);
        end
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (sec_tick) ticks++;
        end
        tests++;
        if (time_bcd !== 16'h0010) begin
            fails++; $display("FAIL up_time40 got %h want 0010", time_bcd);
        end
        tests++;
        if (ticks !== 10) begin
            fails++; $display("FAIL up_ticks got %0d want 10", ticks);
        end
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (sec_tick1) ticks1++;
        end
        tests++;
        if (time_bcd !== 16'h0012) begin
            fails++; $display("FAIL up_time48 got %h want 0012", time_bcd);
        end
        tests++;
        if (time1 !== 4'h9 || ticks1 !== 2) begin
            fails++; $display("FAIL up_sat1 got %h/%0d want 9/2", time1, ticks1);
        end
        game_over = 1'b1;
        step(1);
        game_over = 1'b0;
        tests++;
        if (state !== 2'd2) begin
            fails++; $display("FAIL up_over got %0d want 2", state);
        end
        step(1);
        tests++;
        if (new_high !== 1'b0 || high_bcd !== 8'h0) begin
            fails++; $display("FAIL up_nohigh got %b/%h want 0/00", new_high, high_bcd);
        end
    endtask

    task automatic test_count_down;
        int ticks;
        int ups;
        logic [15:0] want;
        ticks = 0; ups = 0; want = 16'h3;
        count_down = 1'b1; time_limit = 16'h0003; time_limit1 = 4'h0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        tests++;
        if (state !== 2'd1 || time_bcd !== 16'h0003 || time_up !== 1'b0) begin
            fails++;
            $display("FAIL dn_start got %0d/%h/%b want 1/0003/0",
                     state, time_bcd, time_up);
        end
        tests++;
        if (state1 !== 2'd1 || time_up1 !== 1'b1) begin
            fails++; $display("FAIL dn_zero_up got %0d/%b want 1/1", state1, time_up1);
        end
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (k == 0) begin
                tests++;
                if (state1 !== 2'd2) begin
                    fails++; $display("FAIL dn_zero_over got %0d want 2", state1);
                end
            end
            if (time_up) ups++;
            if (sec_tick) begin
                ticks++;
                tests++;
                if (time_bcd !== want) begin
                    fails++; $display("FAIL dn_tick_time got %h want %h", time_bcd, want);
                end
                want = want - 16'h1;
            end
        end
        tests++;
        if (ticks !== 3 || time_bcd !== 16'h0) begin
            fails++; $display("FAIL dn_end got %0d/%h want 3/0000", ticks, time_bcd);
        end
        tests++;
        if (time_up !== 1'b1 || ups !== 1 || state !== 2'd1) begin
            fails++;
            $display("FAIL dn_time_up got %b/%0d/%0d want 1/1/1", time_up, ups, state);
        end
        step(1);
        tests++;
        if (state !== 2'd2 || time_up !== 1'b0) begin
            fails++; $display("FAIL dn_over got %0d/%b want 2/0", state, time_up);
        end
    endtask

    task automatic test_scoring;
        count_down = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            point = (k < 5) ? 2'b11 : 2'b01;
            step(1);
        end
        point = 2'b00;
        tests++;
        if (score_bcd !== 16'h0512) begin
            fails++; $display("FAIL g1_scores got %h want 0512", score_bcd);
        end
        game_over = 1'b1;
        step(1);
        game_over = 1'b0;
        tests++;
        if (state !== 2'd2 || high_bcd !== 8'h0 || new_high !== 1'b0) begin
            fails++;
            $display("FAIL g1_over got %0d/%h/%b want 2/00/0", state, high_bcd, new_high);
        end
        step(1);
        tests++;
        if (high_bcd !== 8'h12 || new_high !== 1'b1) begin
            fails++; $display("FAIL g1_high got %h/%b want 12/1", high_bcd, new_high);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        tests++;
        if (score_bcd !== 16'h0 || new_high !== 1'b0 || high_bcd !== 8'h12) begin
            fails++;
            $display("FAIL g2_start got %h/%b/%h want 0000/0/12",
                     score_bcd, new_high, high_bcd);
        end
        for (int k = 0; k < 6; k++) begin
            point = (k < 3) ? 2'b11 : 2'b01;
            step(1);
        end
        point = 2'b01; game_over = 1'b1;
        step(1);
        point = 2'b00; game_over = 1'b0;
        tests++;
        if (state !== 2'd2 || score_bcd !== 16'h0307) begin
            fails++;
            $display("FAIL g2_point_with_over got %0d/%h want 2/0307", state, score_bcd);
        end
        step(2);
        tests++;
        if (high_bcd !== 8'h12 || new_high !== 1'b0) begin
            fails++; $display("FAIL g2_high got %h/%b want 12/0", high_bcd, new_high);
        end
    endtask

    task automatic test_reset_mid_run;
        count_down = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0; point = 2'b10;
        step(6);
        point = 2'b00;
        tests++;
        if (state !== 2'd1 || high_bcd !== 8'h12 || score_bcd !== 16'h0600) begin
            fails++;
            $display("FAIL mid_pre got %0d/%h/%h want 1/12/0600",
                     state, high_bcd, score_bcd);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        tests++;
        if (state !== 2'd0 || score_bcd !== 16'h0 || high_bcd !== 8'h0 ||
            time_bcd !== 16'h0 || {sec_tick, time_up, new_high} !== 3'b000) begin
            fails++;
            $display("FAIL mid_reset got %0d/%h/%h/%h/%b want 0/0/0/0/000",
                     state, score_bcd, high_bcd, time_bcd,
                     {sec_tick, time_up, new_high});
        end
    endtask

    task automatic test_saturation;
        count_down = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        point = 2'b01;
        step(105);
        point = 2'b00;
        tests++;
        if (score_bcd !== 16'h0099) begin
            fails++; $display("FAIL sat_score got %h want 0099", score_bcd);
        end
        start = 1'b1; game_over = 1'b1;
        step(1);
        start = 1'b0; game_over = 1'b0;
        tests++;
        if (state !== 2'd2 || score_bcd !== 16'h0099) begin
            fails++;
            $display("FAIL start_with_over got %0d/%h want 2/0099", state, score_bcd);
        end
        point = 2'b11;
        step(1);
        point = 2'b00;
        tests++;
        if (high_bcd !== 8'h99 || new_high !== 1'b1 || score_bcd !== 16'h0099) begin
            fails++;
            $display("FAIL over_frozen got %h/%b/%h want 99/1/0099",
                     high_bcd, new_high, score_bcd);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; count_down = 1'b0;
        time_limit = 16'h0; time_limit1 = 4'h0;
        point = 2'b00; game_over = 1'b0;
        step(1);
        test_reset;
        test_count_up;
        test_count_down;
        test_scoring;
        test_reset_mid_run;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_scoreboard.md
# game_scoreboard

Parametrised scoreboard and game timer shared by the snake and tron engines. It tracks per-player scores, a session high score and a seconds timer (count-up or countdown), all as packed BCD, and runs the IDLE/RUN/OVER game-phase sequence. It sits between the game engines and the HEX digit decoders. It generalises the fixed two-digit score, high-score and four-digit time displays to N players and configurable digit counts, and adds countdown mode and saturation.

## Interface
- CLK_HZ, 50000000, clk cycles per timer second; minimum 2.
- NUM_PLAYERS, 2, number of score channels; 1..4.
- SCORE_DIGITS, 2, BCD digits per score and high score; 1..4.
- TIME_DIGITS, 4, BCD digits of the timer; 1..4.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where it is sampled high.
- start  in  1  level; sampled in IDLE or OVER to begin a game.
- count_down  in  1  timer mode, latched at start: 1 = countdown, 0 = count-up.
- time_limit  in  4*TIME_DIGITS  BCD countdown start value, latched at start.
- point  in  NUM_PLAYERS  bit i high for one cycle = one point for player i.
- game_over  in  1  engine-reported end of game.
- state  out  2  phase: 0 = IDLE, 1 = RUN, 2 = OVER. Encoding 3 is never produced.
- score_bcd  out  NUM_PLAYERS*4*SCORE_DIGITS  player i occupies slice [i*4*SCORE_DIGITS +: 4*SCORE_DIGITS].
- high_bcd  out  4*SCORE_DIGITS  session high score.
- time_bcd  out  4*TIME_DIGITS  timer value in seconds.
- sec_tick  out  1  one-cycle pulse on each timer step.
- time_up  out  1  one-cycle pulse when the countdown expires.
- new_high  out  1  high in OVER when this game raised high_bcd.

## Operation
- Reset values: state = IDLE, and every other output is 0.
  - high_bcd is cleared only by reset; start does not clear it.
- IDLE/OVER, start = 1:
  - Next state is RUN.
  - All scores are cleared.
  - Prescaler is cleared.
  - Mode is latched from count_down.
  - time_bcd is loaded with time_limit in countdown mode, or with 0 in count-up mode.
  - new_high is cleared.
- RUN:
  - The prescaler counts 0..CLK_HZ-1 and wraps.
  - At the CLK_HZ-1 cycle, sec_tick = 1 and the timer steps on the same edge.
  - Count-up: BCD increment with per-digit carry. The timer saturates at all 9s; sec_tick still pulses.
  - Countdown: BCD decrement with per-digit borrow.
  - Countdown expiry: while in RUN with time_bcd == 0, time_up = 1 for that cycle and the next state is OVER. A zero time_limit therefore ends the game on the first RUN cycle.
  - point[i]: score i is incremented in BCD and saturates at all 9s. Simultaneous bits are each applied independently.
  - game_over = 1: next state is OVER. Points in the same cycle are still counted.
  - start is ignored in RUN. If start and game_over are both high, game_over wins.
- OVER:
  - Scores and timer are frozen; point and game_over are ignored.
  - Each cycle, max = largest player score, compared as unsigned packed BCD (order-preserving).
  - If max > high_bcd, then high_bcd <= max and new_high <= 1. Equality does not update.
- reset asserted in any state overrides all other inputs. This includes a reset mid-RUN.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- start sampled at edge t: state = RUN and the loaded time are visible after edge t.
- The first sec_tick occurs CLK_HZ cycles after entering RUN. Subsequent ticks are every CLK_HZ cycles.
- point sampled at edge t: the updated score is visible after t. Latency is 1.
- Timer step:
  - The tick cycle is sampled at edge t, and the new time is visible after t.
  - If the new time is 0 in countdown mode, time_up is high in the cycle after t.
  - state = OVER after the next edge.
- game_over sampled at edge t: state = OVER after t. high_bcd and new_high update one edge later.

## Test plan
- Reset: after a 2-cycle reset pulse, state = 0 and score_bcd, high_bcd, time_bcd, sec_tick, time_up and new_high are all 0. Holding point and start high during reset changes nothing.
- Count-up (CLK_HZ = 4, TIME_DIGITS = 4): start with count_down = 0, run 40 cycles -> time_bcd = 0x0010 and 10 sec_tick pulses. With TIME_DIGITS = 1, after 12 ticks -> time_bcd = 0x9.
- Countdown (CLK_HZ = 4, time_limit = 0x0003):
  - 3 sec_tick pulses, with time going 3→2→1→0.
  - time_up on the cycle after the third tick, then state = 2.
  - Separately, time_limit = 0 -> time_up on the first RUN cycle.
- Scoring (NUM_PLAYERS = 2):
  - Game 1: 12 pulses on point[0] and 5 on point[1], 5 of them simultaneous, then game_over -> scores 0x12/0x05, high_bcd = 0x12, new_high = 1.
  - Game 2: max score 0x07 -> high_bcd stays 0x12 and new_high = 0.
- Saturation and boundaries:
  - 105 point[0] pulses with SCORE_DIGITS = 2 -> 0x99.
  - point together with game_over in the same cycle is counted.
  - start together with game_over in RUN -> OVER.
- Reset mid-RUN with high_bcd = 0x12 -> every output returns to 0 and state = IDLE on the next edge.
